// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory slave.
//   dmem_state_t : transaction FSM states (IDLE, WAIT, RESP)
//   DMEM_WORD_W  : RAM word width in bits
//   DMEM_BE_W    : byte-enable width (one bit per byte lane)
//   DMEM_CNT_W   : wait-state counter width (WAIT_CYCLES range 0..15)
//   Default MEM_WORDS / WAIT_CYCLES values for dmem_slave.
package dmem_pkg;

    localparam int unsigned DMEM_WORD_W          = 32;
    localparam int unsigned DMEM_BE_W            = 4;
    localparam int unsigned DMEM_CNT_W           = 4;
    localparam int unsigned DMEM_MEM_WORDS_DEF   = 1024;
    localparam int unsigned DMEM_WAIT_CYCLES_DEF = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM, per-byte write enables, registered read.
// Ports:
//   clk   in  clock, rising edge
//   en    in  access enable for this cycle
//   we    in  1 = write the enabled lanes, 0 = read into rdata
//   be    in  byte enables, bit n selects bits [8n+7:8n]
//   idx   in  word index
//   wdata in  write data, lane-aligned
//   rdata out registered read data; updated only by a read access
// Contents and rdata are not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DMEM_MEM_WORDS_DEF,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [DMEM_BE_W-1:0]   be,
    input  logic [IDX_W-1:0]       idx,
    input  logic [DMEM_WORD_W-1:0] wdata,
    output logic [DMEM_WORD_W-1:0] rdata
);

    logic [DMEM_WORD_W-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DMEM_BE_W; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem_q[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_slave.sv
// dmem_slave: data-memory slave behind the CPU load/store unit.
// One outstanding transaction over a req/gnt/rvalid handshake, WAIT_CYCLES extra cycles
// between accept and response, internal byte-enabled word RAM (dmem_array).
// Ports:
//   clk           in  clock, rising edge
//   rst_n         in  asynchronous active-low reset
//   data_req_i    in  request valid
//   data_add_i    in  byte address, bits [1:0] ignored
//   data_we_i     in  1 = write, 0 = read
//   data_be_i     in  byte enables
//   data_wdata_i  in  lane-aligned write data
//   data_gnt_o    out request accepted this cycle (combinational)
//   data_rvalid_o out one-cycle response pulse per accepted request
//   data_rdata_o  out read data, valid with rvalid for reads
//   data_err_o    out response error, qualified by rvalid
// Optional build macro DMEM_ERR_EN: out-of-range addresses respond with err=1, rdata=0 and
// suppress writes. Without it the word index wraps modulo MEM_WORDS and err is always 0.
module dmem_slave
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = DMEM_MEM_WORDS_DEF,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES_DEF,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   data_req_i,
    input  logic [31:0]            data_add_i,
    input  logic                   data_we_i,
    input  logic [DMEM_BE_W-1:0]   data_be_i,
    input  logic [DMEM_WORD_W-1:0] data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic [DMEM_WORD_W-1:0] data_rdata_o,
    output logic                   data_err_o
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam logic [DMEM_CNT_W-1:0] WaitInit =
        (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);

    dmem_state_t state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;

    // Latched request, used when the RAM access happens after wait states.
    logic [IdxW-1:0]        idx_q;
    logic                   we_q;
    logic [DMEM_BE_W-1:0]   be_q;
    logic [DMEM_WORD_W-1:0] wdata_q;
    logic                   oor_q;

    logic err_q;
    // Set once a real read has loaded the RAM read register; keeps rdata at 0 out of reset.
    logic rd_seen_q;

    logic [IdxW-1:0] req_idx;
    logic            req_oor;
    logic            accept;

    logic                   acc_en;
    logic                   acc_direct;
    logic                   acc_we;
    logic [DMEM_BE_W-1:0]   acc_be;
    logic [IdxW-1:0]        acc_idx;
    logic [DMEM_WORD_W-1:0] acc_wdata;
    logic                   acc_oor;
    logic                   ram_en;
    logic [DMEM_WORD_W-1:0] ram_rdata;

    // Upper bits beyond the index width are dropped, so addresses alias modulo MEM_WORDS.
    assign req_idx = IdxW'((data_add_i - BASE_ADDR) >> 2);

`ifdef DMEM_ERR_EN
    localparam logic [32:0] Span = 33'(MEM_WORDS) << 2;
    logic [32:0] off_ext;
    // Addresses below BASE_ADDR borrow into bit 32 and therefore also compare >= Span.
    assign off_ext = {1'b0, data_add_i} - {1'b0, BASE_ADDR};
    assign req_oor = (off_ext >= Span);
`else
    assign req_oor = 1'b0;
`endif

    assign data_gnt_o = data_req_i && ((state_q == IDLE) || (state_q == RESP));
    assign accept     = data_req_i && data_gnt_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WaitInit;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The RAM is accessed on the edge that enters RESP: straight from the bus with no wait
    // states, otherwise from the latched request at the end of WAIT.
    always_comb begin
        acc_direct = accept && (WAIT_CYCLES == 0);
        acc_en     = acc_direct || ((state_q == WAIT) && (cnt_q == '0));
        acc_we     = acc_direct ? data_we_i    : we_q;
        acc_be     = acc_direct ? data_be_i    : be_q;
        acc_idx    = acc_direct ? req_idx      : idx_q;
        acc_wdata  = acc_direct ? data_wdata_i : wdata_q;
        acc_oor    = acc_direct ? req_oor      : oor_q;
        ram_en     = acc_en && !acc_oor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= req_idx;
                we_q    <= data_we_i;
                be_q    <= data_be_i;
                wdata_q <= data_wdata_i;
                oor_q   <= req_oor;
            end
            if (acc_en) begin
                err_q <= acc_oor;
                if (!acc_we && !acc_oor) begin
                    rd_seen_q <= 1'b1;
                end
            end
        end
    end

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IdxW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (acc_we),
        .be    (acc_be),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign data_rvalid_o = (state_q == RESP);
    assign data_err_o    = err_q && data_rvalid_o;
    assign data_rdata_o  = (rd_seen_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_slave.sv
// Bench for dmem_slave: three instances (WAIT_CYCLES 0, 3, 2) sharing one clock.
// Expected responses come from a per-instance memory model and are queued when a
// request is granted; a monitor pops and compares them on rvalid.
module tb_dmem_slave;

    localparam int unsigned MemWords = 16;
    localparam logic [31:0] Base     = 32'h0000_0000;

    typedef struct {
        int          inst;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n  [3];
    logic        req    [3];
    logic [31:0] add    [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    logic [31:0] model [3][MemWords];
    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Wc = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
        dmem_slave #(
            .MEM_WORDS   (MemWords),
            .WAIT_CYCLES (Wc),
            .BASE_ADDR   (Base)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n[g]),
            .data_req_i    (req[g]),
            .data_add_i    (add[g]),
            .data_we_i     (we[g]),
            .data_be_i     (be[g]),
            .data_wdata_i  (wdata[g]),
            .data_gnt_o    (gnt[g]),
            .data_rvalid_o (rvalid[g]),
            .data_rdata_o  (rdata[g]),
            .data_err_o    (err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_oor(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return ((a - Base) >= 32'(4 * MemWords));
`else
        return (a === 32'hxxxx_xxxx);
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] w;
        w = (a - Base) >> 2;
        return int'(w % MemWords);
    endfunction

    task automatic push_exp(input int g, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        exp_t e;
        int   k;
        k       = word_of(a);
        e.inst  = g;
        e.we    = w;
        e.err   = is_oor(a);
        e.rdata = '0;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) model[g][k][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                e.rdata = model[g][k];
            end
        end
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        req[g]   = 1'b1;
        add[g]   = a;
        we[g]    = w;
        be[g]    = b;
        wdata[g] = d;
    endtask

    task automatic idle(input int g);
        req[g] = 1'b0;
        we[g]  = 1'b0;
        be[g]  = 4'h0;
    endtask

    // Drive a request, wait (bounded) for grant, queue its expected response, pass the
    // accept edge. Returns at posedge+1 with req still asserted.
    task automatic issue(input int g, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        int n;
        n = 0;
        drive(g, a, w, b, d);
        @(negedge clk);
        while (!gnt[g] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!gnt[g]) chk($sformatf("gnt_timeout%0d", g), 32'(gnt[g]), 32'd1);
        else push_exp(g, a, w, b, d);
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Response monitor: every rvalid must match the oldest queued entry of its instance.
    always @(negedge clk) begin : mon
        int   idx;
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (rvalid[g] === 1'b1) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].inst == g) idx = i;
                if (idx < 0) begin
                    chk($sformatf("unexpected_rvalid%0d", g), 32'(rvalid[g]), 32'd0);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    chk($sformatf("err%0d", g), 32'(err[g]), 32'(e.err));
                    if (!e.we) chk($sformatf("rdata%0d", g), rdata[g], e.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0;
            idle(g);
            add[g]   = '0;
            wdata[g] = '0;
        end

        // Reset then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_gnt%0d", g), 32'(gnt[g]), 32'd0);
            chk($sformatf("rst_rvalid%0d", g), 32'(rvalid[g]), 32'd0);
            chk($sformatf("rst_err%0d", g), 32'(err[g]), 32'd0);
            chk($sformatf("rst_rdata%0d", g), rdata[g], 32'd0);
        end
        step();
        for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
        @(negedge clk);
        chk("idle_rvalid0", 32'(rvalid[0]), 32'd0);

        // WAIT_CYCLES=0: back-to-back write then read of the same word.
        step();
        issue(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        drive(0, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("b2b_gnt", 32'(gnt[0]), 32'd1);
        chk("wr_rvalid_lat", 32'(rvalid[0]), 32'd1);
        push_exp(0, 32'h10, 1'b0, 4'h0, 32'h0);
        step();
        idle(0);
        @(negedge clk);
        chk("rd_rvalid_lat", 32'(rvalid[0]), 32'd1);
        chk("rd_rdata_direct", rdata[0], 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rvalid_pulse", 32'(rvalid[0]), 32'd0);

        // Byte enables, including an all-zero mask.
        step();
        issue(0, 32'h20, 1'b1, 4'hF, 32'hAABB_CCDD);
        issue(0, 32'h20, 1'b1, 4'b0101, 32'h1122_3344);
        issue(0, 32'h20, 1'b0, 4'h0, 32'h0);
        idle(0);
        @(negedge clk);
        chk("be_merge_direct", rdata[0], 32'hAA22_CC44);
        step();
        issue(0, 32'h20, 1'b1, 4'h0, 32'hFFFF_FFFF);
        issue(0, 32'h20, 1'b0, 4'h0, 32'h0);
        idle(0);
        drain();

        // Out-of-range address: error response with the macro, alias of word 0 without.
        step();
        issue(0, 32'h0, 1'b1, 4'hF, 32'h0BAD_F00D);
        issue(0, 32'h40, 1'b1, 4'hF, 32'h5555_5555);
        issue(0, 32'h40, 1'b0, 4'h0, 32'h0);
        issue(0, 32'h0, 1'b0, 4'h0, 32'h0);
        idle(0);
        drain();

        // WAIT_CYCLES=3: grant blocked for three cycles, response on the fourth.
        step();
        issue(1, 32'h8, 1'b1, 4'hF, 32'hCAFE_0001);
        idle(1);
        drain();
        step();
        drive(1, 32'h8, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("w3_first_gnt", 32'(gnt[1]), 32'd1);
        push_exp(1, 32'h8, 1'b0, 4'h0, 32'h0);
        step();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("w3_gnt_t%0d", k), 32'(gnt[1]), 32'd0);
            chk($sformatf("w3_rvalid_t%0d", k), 32'(rvalid[1]), 32'd0);
        end
        @(negedge clk);
        chk("w3_rvalid_t4", 32'(rvalid[1]), 32'd1);
        chk("w3_held_gnt_t4", 32'(gnt[1]), 32'd1);
        push_exp(1, 32'h8, 1'b0, 4'h0, 32'h0);
        step();
        idle(1);
        drain();

        // WAIT_CYCLES=2: reset during WAIT drops the write and its response.
        step();
        issue(2, 32'h14, 1'b1, 4'hF, 32'h1234_5678);
        idle(2);
        drain();
        step();
        drive(2, 32'h14, 1'b1, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rstw_gnt", 32'(gnt[2]), 32'd1);
        step();
        idle(2);
        rst_n[2] = 1'b0;
        @(negedge clk);
        chk("rstw_rvalid_in_rst", 32'(rvalid[2]), 32'd0);
        step();
        rst_n[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rstw_no_rvalid%0d", k), 32'(rvalid[2]), 32'd0);
        end
        step();
        drive(2, 32'h14, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstw_idle_gnt", 32'(gnt[2]), 32'd1);
        push_exp(2, 32'h14, 1'b0, 4'h0, 32'h0);
        step();
        idle(2);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
